// File: rtl/conv_feed_sequencer.sv
// conv_feed_sequencer
//   Emits beat descriptors that stream one kernel and then one feature-map
//   channel through a convolution datapath, for every (kernel, channel) pair.
//   Each pass sends KSZ*KSZ/LANES kernel beats. It then sweeps the KSZ-row
//   window over the feature map, moving CPB columns per beat.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   in_start_conv    : start request, honoured only in IDLE
//   in_abort         : abandon the current job (KERNEL/FMAP only)
//   in_cfg_ci/co     : channel / kernel count codes (0..3 -> 8..32, 4-7 -> 32)
//   in_ready         : downstream accepts the current beat
//   out_valid        : beat descriptor valid
//   out_is_kernel    : 1 = kernel beat, 0 = feature-map beat
//   out_addr         : word address of lane 0
//   out_knl/out_chnl : current kernel / channel index
//   out_row/out_col  : window top row / first column of the beat
//   out_last         : final beat of the job
//   out_busy         : job in progress
//   out_end_conv     : one-cycle completion pulse
module conv_feed_sequencer #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned KSZ   = 4,
  parameter int unsigned LANES = 8,
  parameter int unsigned AW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_start_conv,
  input  logic          in_abort,
  input  logic [2:0]    in_cfg_ci,
  input  logic [2:0]    in_cfg_co,
  input  logic          in_ready,
  output logic          out_valid,
  output logic          out_is_kernel,
  output logic [AW-1:0] out_addr,
  output logic [4:0]    out_knl,
  output logic [4:0]    out_chnl,
  output logic [7:0]    out_row,
  output logic [7:0]    out_col,
  output logic          out_last,
  output logic          out_busy,
  output logic          out_end_conv
);

  localparam int unsigned CPB    = LANES / KSZ;
  localparam int unsigned KBEATS = (KSZ * KSZ) / LANES;
  localparam logic [7:0]  COL_LAST = 8'(IMG_W - CPB);
  localparam logic [7:0]  ROW_LAST = 8'(IMG_H - KSZ);
  localparam logic [7:0]  CPB_L    = 8'(CPB);
  localparam logic [7:0]  KB_LAST  = 8'(KBEATS - 1);

  typedef enum logic [1:0] {IDLE, KERNEL, FMAP, DONE} state_t;

  state_t       state, nxt_state;
  logic [4:0]   ci_m1, co_m1, nxt_ci_m1, nxt_co_m1;
  logic [4:0]   nxt_knl, nxt_chnl;
  logic [7:0]   nxt_row, nxt_col;
  logic [7:0]   kbeat, nxt_kbeat;
  logic         xfer;
  logic [AW-1:0] kaddr, faddr, nxt_addr;
  logic         nxt_last;

  // Codes 4-7 saturate to the 32-channel setting.
  function automatic logic [1:0] clamp_code(input logic [2:0] c);
    return c[2] ? 2'd3 : c[1:0];
  endfunction

  // The descriptor registers double as the iteration counters. The next
  // descriptor is built here and then registered, so every output is a flop.
  // While stalled, the next values equal the current ones, so the outputs hold.
  always_comb begin
    nxt_state = state;
    nxt_ci_m1 = ci_m1;
    nxt_co_m1 = co_m1;
    nxt_knl   = out_knl;
    nxt_chnl  = out_chnl;
    nxt_row   = out_row;
    nxt_col   = out_col;
    nxt_kbeat = kbeat;
    xfer      = out_valid && in_ready;

    case (state)
      IDLE: begin
        if (in_start_conv) begin
          nxt_state = KERNEL;
          nxt_ci_m1 = {clamp_code(in_cfg_ci), 3'b111};
          nxt_co_m1 = {clamp_code(in_cfg_co), 3'b111};
          nxt_knl   = '0;
          nxt_chnl  = '0;
          nxt_row   = '0;
          nxt_col   = '0;
          nxt_kbeat = '0;
        end
      end
      KERNEL: begin
        if (in_abort) begin
          nxt_state = IDLE;
          nxt_knl   = '0;
          nxt_chnl  = '0;
          nxt_kbeat = '0;
        end else if (xfer) begin
          if (kbeat == KB_LAST) begin
            nxt_kbeat = '0;
            nxt_state = FMAP;
          end else begin
            nxt_kbeat = kbeat + 8'd1;
          end
        end
      end
      FMAP: begin
        if (in_abort) begin
          nxt_state = IDLE;
          nxt_knl   = '0;
          nxt_chnl  = '0;
          nxt_row   = '0;
          nxt_col   = '0;
        end else if (xfer) begin
          if (out_col != COL_LAST) begin
            nxt_col = out_col + CPB_L;
          end else begin
            nxt_col = '0;
            if (out_row != ROW_LAST) begin
              nxt_row = out_row + 8'd1;
            end else begin
              nxt_row   = '0;
              nxt_state = KERNEL;
              if (out_chnl != ci_m1) begin
                nxt_chnl = out_chnl + 5'd1;
              end else begin
                nxt_chnl = '0;
                if (out_knl != co_m1) begin
                  nxt_knl = out_knl + 5'd1;
                end else begin
                  nxt_knl   = '0;
                  nxt_state = DONE;
                end
              end
            end
          end
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    kaddr = (AW'(nxt_knl) * (AW'(nxt_ci_m1) + AW'(1)) + AW'(nxt_chnl)) * AW'(KSZ * KSZ)
            + AW'(nxt_kbeat) * AW'(LANES);
    faddr = AW'(nxt_chnl) * AW'(IMG_W * IMG_H) + AW'(nxt_row) * AW'(IMG_W) + AW'(nxt_col);

    case (nxt_state)
      KERNEL:  nxt_addr = kaddr;
      FMAP:    nxt_addr = faddr;
      default: nxt_addr = '0;
    endcase

    nxt_last = (nxt_state == FMAP) && (nxt_knl == nxt_co_m1) && (nxt_chnl == nxt_ci_m1)
               && (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ci_m1         <= '0;
      co_m1         <= '0;
      kbeat         <= '0;
      out_valid     <= 1'b0;
      out_is_kernel <= 1'b0;
      out_addr      <= '0;
      out_knl       <= '0;
      out_chnl      <= '0;
      out_row       <= '0;
      out_col       <= '0;
      out_last      <= 1'b0;
      out_busy      <= 1'b0;
      out_end_conv  <= 1'b0;
    end else begin
      state         <= nxt_state;
      ci_m1         <= nxt_ci_m1;
      co_m1         <= nxt_co_m1;
      kbeat         <= nxt_kbeat;
      out_valid     <= (nxt_state == KERNEL) || (nxt_state == FMAP);
      out_busy      <= (nxt_state == KERNEL) || (nxt_state == FMAP);
      out_is_kernel <= (nxt_state == KERNEL);
      out_end_conv  <= (nxt_state == DONE);
      out_addr      <= nxt_addr;
      out_knl       <= nxt_knl;
      out_chnl      <= nxt_chnl;
      out_row       <= nxt_row;
      out_col       <= nxt_col;
      out_last      <= nxt_last;
    end
  end

endmodule

// File: doc/conv_feed_sequencer.md
CONV_FEED_SEQUENCER -- requirements
Module: conv_feed_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning feature-map width; must be a multiple of CPB.
REQ-002 SHALL have parameter IMG_H, default 64, meaning feature-map height; must be at least KSZ.
REQ-003 SHALL have parameter KSZ, default 4, meaning kernel edge.
REQ-004 SHALL have parameter LANES, default 8, meaning data lanes per beat; CPB=LANES/KSZ is columns per beat, and KSZ*KSZ must be a multiple of LANES.
REQ-005 SHALL have parameter AW, default 20, meaning word-address width.
REQ-006 SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_start_conv, in, 1, start request.
- in_abort, in, 1, abandon the current job.
- in_cfg_ci, in, 3, channel count code: 0=8, 1=16, 2=24, 3=32.
- in_cfg_co, in, 3, kernel count code, same encoding as in_cfg_ci.
- in_ready, in, 1, downstream accepts the beat.
- out_valid, out, 1, beat descriptor valid.
- out_is_kernel, out, 1, beat is kernel data (1) or feature-map data (0).
- out_addr, out, AW, word address of lane 0.
- out_knl, out, 5, current kernel index.
- out_chnl, out, 5, current channel index.
- out_row, out, 8, window top row.
- out_col, out, 8, first column of the beat.
- out_last, out, 1, final beat of the job.
- out_busy, out, 1, job in progress.
- out_end_conv, out, 1, one-cycle pulse marking job completion.

Function
REQ-007 SHALL implement the states IDLE, KERNEL, FMAP and DONE.
REQ-008 In IDLE, in_start_conv=1 SHALL latch CI=8*(min(in_cfg_ci,3)+1) and CO=8*(min(in_cfg_co,3)+1), clear all counters, and enter KERNEL; codes 4-7 are treated as 3.
REQ-009 out_valid SHALL assert on the edge after start is accepted, giving a first-beat latency of 1 cycle.
REQ-010 A beat SHALL transfer only on a rising edge where out_valid=1 and in_ready=1.
REQ-011 While out_valid=1 and in_ready=0, all out_* descriptor fields SHALL hold stable.
REQ-012 KERNEL SHALL issue KSZ*KSZ/LANES beats (b=0..); out_addr=(knl*CI+chnl)*KSZ*KSZ+b*LANES; row and col are 0.
REQ-013 After the last kernel beat transfers, the block SHALL enter FMAP with row=0 and col=0.
REQ-014 FMAP beats SHALL use out_addr=chnl*IMG_W*IMG_H+row*IMG_W+col.
- The downstream lane mapping is fixed: lane c*KSZ+r equals element (row+r, col+c).
REQ-015 After each FMAP transfer, col SHALL advance by CPB; at col=IMG_W-CPB, col wraps to 0 and row increments.
REQ-016 After the transfer at row=IMG_H-KSZ, col=IMG_W-CPB, chnl SHALL increment and the block re-enters KERNEL.
REQ-017 When chnl=CI-1 wraps, chnl SHALL go to 0 and knl increments.
REQ-018 When knl=CO-1 wraps, the block SHALL enter DONE instead.
REQ-019 out_last SHALL be 1 only on the beat knl=CO-1, chnl=CI-1, row=IMG_H-KSZ, col=IMG_W-CPB, in FMAP.
REQ-020 DONE SHALL drive out_end_conv=1 and out_valid=0 for exactly one cycle, then return to IDLE.
REQ-021 out_busy SHALL be 1 in KERNEL and FMAP, and 0 in IDLE and DONE.
REQ-022 in_start_conv SHALL be ignored outside IDLE; configuration changes mid-job SHALL have no effect.
REQ-023 in_abort=1 in KERNEL or FMAP SHALL force IDLE at the next edge with out_valid=0, and no out_end_conv pulse.
- in_abort takes priority over a simultaneous transfer.
- in_abort is ignored in IDLE and DONE.
REQ-024 Start and abort asserted in the same IDLE cycle SHALL be resolved by start winning.
REQ-025 Address arithmetic SHALL be unsigned, truncated to AW bits; all counters SHALL be sized for CI=CO=32 maximum.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and set all outputs and counters to 0.
- This applies at any time, including mid-job; a job is never resumed after reset.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which rst_n=1.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- cfg_ci=0, cfg_co=0, in_ready=1 -> addr sequence 0, 8, then 0, 2, ..., 62, then 64; exactly 64*1954=125056 beats; a single end pulse.
- After the 1954th beat -> kernel addr 16, then fmap addr 4096, with chnl=1.
- Random in_ready with 50% duty -> beat sequence identical to the in_ready=1 run; descriptors stable while stalled.
- cfg_ci=7, cfg_co=5 -> CI=CO=32; last beat knl=31, chnl=31, row=60, col=62, addr=31*4096+60*64+62; out_last=1.
- in_abort at beat 100 -> out_valid=0 next cycle; no end pulse; a fresh start restarts at addr 0.
- Start pulses while busy, and rst_n low mid-FMAP -> starts ignored; reset clears all outputs immediately, asynchronously.
